// File: rtl/ifetch_req_ctrl.sv
// ifetch_req_ctrl
//   Pre-IF fetch sequencer. Sits between the next-PC mux and the IF stage and
//   drives a SRAM-like instruction bus (req / addr_ok / data_ok). It owns the
//   fetch PC and keeps at most one live request on the bus. The returned
//   instruction is buffered until IF takes it. Requests that a redirect has
//   killed are counted, so their late responses can be recognised and dropped.
//
// Parameters
//   RESET_PC  fetch PC after reset
//   CANCEL_W  width of the cancelled-response counter; up to 2**CANCEL_W-1
//             killed responses may be in flight
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   inst_sram_req      request valid
//   inst_sram_wr       always 0 (read-only bus)
//   inst_sram_size     always 2'b10 (word)
//   inst_sram_addr     request address (the fetch PC)
//   inst_sram_addr_ok  request accepted this cycle
//   inst_sram_data_ok  response valid this cycle (in order)
//   inst_sram_rdata    response data
//   redirect_valid     flush/branch redirect; wins over every other event
//   redirect_pc        new fetch target
//   fs_allowin         IF accepts the buffered instruction this cycle
//   fs_valid           buffered instruction valid
//   fs_pc, fs_inst     PC and instruction of the buffered entry
//   perf_fetch_cnt     delivered instructions
//   perf_stall_cnt     cycles with req=1 and addr_ok=0
//
// Build option
//   IFETCH_PERF_EN  when defined, the two perf counters are real 32-bit
//                   wrapping counters. Otherwise the ports are tied to zero.

module ifetch_req_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          CANCEL_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fs_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;
  localparam logic [CANCEL_W-1:0] CANCEL_ONE = CANCEL_W'(1);

  state_t              state, state_nxt;
  logic [31:0]         fetch_pc, fetch_pc_nxt;
  logic [CANCEL_W-1:0] cancel_cnt, cancel_cnt_nxt;
  logic                accept;
  logic                cancel_inc;
  logic                cancel_dec;
  logic                capture;

  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'b10;
  assign inst_sram_addr = fetch_pc;

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    cancel_inc    = 1'b0;
    capture       = 1'b0;
    inst_sram_req = 1'b0;
    fs_valid      = 1'b0;

    // A saturated cancel counter blocks new requests; otherwise a fresh
    // request could be killed with no room left to record it.
    if (state == S_REQ) begin
      inst_sram_req = (cancel_cnt != CANCEL_MAX);
    end
    if (state == S_HOLD) begin
      fs_valid = ~redirect_valid;
    end

    accept = inst_sram_req & inst_sram_addr_ok;
    // Responses arrive in order, so while killed requests are outstanding
    // every data_ok belongs to one of them.
    cancel_dec = inst_sram_data_ok & (cancel_cnt != '0);

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          cancel_inc   = accept;
        end else if (accept) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = S_REQ;
          // The live response is killed. If it returns in this same cycle it
          // is simply dropped; otherwise it still has to be counted.
          cancel_inc   = ~(inst_sram_data_ok & (cancel_cnt == '0));
        end else if (inst_sram_data_ok && (cancel_cnt == '0)) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = S_REQ;
        end else if (fs_allowin) begin
          fetch_pc_nxt = fs_pc + 32'd4;
          state_nxt    = S_REQ;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    cancel_cnt_nxt = cancel_cnt;
    if (cancel_inc && !cancel_dec) begin
      cancel_cnt_nxt = cancel_cnt + CANCEL_ONE;
    end else if (!cancel_inc && cancel_dec) begin
      cancel_cnt_nxt = cancel_cnt - CANCEL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      cancel_cnt <= '0;
      fs_pc      <= RESET_PC;
      fs_inst    <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      cancel_cnt <= cancel_cnt_nxt;
      if (capture) begin
        fs_pc   <= fetch_pc;
        fs_inst <= inst_sram_rdata;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic perf_fetch_inc;
  logic perf_stall_inc;

  assign perf_fetch_inc = (state == S_HOLD) & fs_allowin & ~redirect_valid;
  assign perf_stall_inc = inst_sram_req & ~inst_sram_addr_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (perf_fetch_inc) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (perf_stall_inc) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_fetch_cnt = 32'b0;
  assign perf_stall_cnt = 32'b0;
`endif

endmodule
